present_serial_core: RTL and testbench
======================================

// Module: present_serial_core
// PURPOSE
//   Nibble-serial PRESENT-80 encryption core. Runs 31 rounds over a 64-bit state:
//   addRoundKey, then sLayer one nibble per cycle through a single s_box, then pLayer.
//   The 80-bit key schedule runs alongside the rounds. Sits between the host/IO
//   shift logic and the s_box stage; it feeds s_box and consumes its output.
// PARAMETERS
//   ROUNDS  31  number of full rounds; the final key whitening always follows.
//               Valid range 1..31. Non-31 values are for reduced-round test only.
// PORTS
//   Clk_ik         in   1   clock, single domain
//   Rst_ir         in   1   asynchronous, active-high reset
//   Start_i        in   1   request encryption; sampled only in IDLE
//   Plaintext_ib   in   64  plaintext; captured on the accepted Start_i cycle
//   Key_ib         in   80  key; captured on the accepted Start_i cycle
//   Busy_o         out  1   high from the cycle after accept until the Done_o cycle, inclusive
//   Done_o         out  1   one-cycle pulse; Ciphertext_ob valid from this cycle
//   Ciphertext_ob  out  64  result; held until the next accepted Start_i
// BEHAVIOUR
//   Reset (async, active-high): FSM=IDLE; state, key, counters=0; Busy_o=0; Done_o=0;
//     Ciphertext_ob=0.
//   FSM states: IDLE, ADDKEY, SBOX, PERM, FINAL.
//   IDLE:
//     - Start_i=1: state<=Plaintext_ib; key<=Key_ib; round<=1; go to ADDKEY.
//     - Start_i=0: stay in IDLE.
//   ADDKEY (1 cycle): state<=state^key[79:16]; nib<=0; go to SBOX.
//   SBOX (16 cycles, nib 0..15):
//     - state<={s_box(state[3:0]),state[63:4]}, a rotate-right by one nibble.
//     - After 16 cycles every nibble is substituted and back in its original position.
//     - nib==15: go to PERM.
//   PERM (1 cycle):
//     - state<=pLayer(state): bit i moves to 16*i mod 63; bit 63 stays fixed.
//     - key update: k'=key rotated left 61.
//     - k'[79:76]=s_box(k'[79:76]), using a second s_box instance.
//     - k'[19:15]^=round[4:0].
//     - round==ROUNDS: go to FINAL. Else round<=round+1 and go to ADDKEY.
//   FINAL (1 cycle):
//     - Ciphertext_ob<=state^key[79:16]; Done_o=1 this cycle; go to IDLE.
//   Latency: accept cycle T; Done_o at T+1+18*ROUNDS+1. For ROUNDS=31 that is T+560.
//   Busy_o=1 in ADDKEY/SBOX/PERM/FINAL.
//   Start_i while not IDLE: ignored, no queueing.
//   Start_i on the cycle after FINAL: accepted (back-to-back allowed).
//   Reset mid-operation: aborts immediately. Ciphertext_ob returns to 0.
//     No Done_o pulse is produced.
//   Width rules:
//     - round is a 5-bit counter, max 31, never wraps for valid ROUNDS.
//     - nib is a 4-bit counter and wraps 15->0 on leaving SBOX.
//   Inputs are sampled only on the accept cycle. Later changes do not affect the result.
// STRUCTURE
//   Shared package present_pkg holds:
//     - state widths STATE_W=64 and KEY_W=80
//     - FSM state encoding
//     - function p_layer(64b)->64b
//     - function key_update(80b key, 5b round)->80b, with the s_box nibble passed in
//   Sub-module: existing s_box, instantiated twice (datapath nibble, key top nibble).
//   No other sub-modules. pLayer is pure wiring inside the package function.
// TESTING
//   1 pt=0, key=0, Start_i pulse -> Done_o after 560 cycles, Ciphertext_ob=64'h5579C1387B228445
//   2 pt=0, key=80'hFFFF_FFFF_FFFF_FFFF_FFFF -> 64'hE72C46C0F5945049
//   3 pt=64'hFFFFFFFFFFFFFFFF, key=0 -> 64'hA112FFC72F68417B
//   4 pt=all-ones, key=all-ones, then Start_i asserted again on the cycle after Done_o
//       -> 64'h3333DCD3213210D2; second run also gives 64'h3333DCD3213210D2 after 560 cycles
//   5 Start_i re-pulsed at cycles T+5 and T+300 with different inputs
//       -> ignored; result equals case 1. Busy_o stays 1 throughout the run.
//   6 Rst_ir asserted at T+200 -> Busy_o=0, Ciphertext_ob=0, no Done_o.
//       Then a new Start_i (case 2 inputs) -> 64'hE72C46C0F5945049

Source files
------------

// File: rtl/present_pkg.sv
// Shared definitions for the nibble-serial PRESENT-80 core: widths, FSM
// encoding and the pure-wiring round helpers (pLayer and key schedule).
package present_pkg;

  localparam int STATE_W = 64;
  localparam int KEY_W   = 80;
  localparam int ROUND_W = 5;
  localparam int NIB_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDKEY = 3'd1,
    ST_SBOX   = 3'd2,
    ST_PERM   = 3'd3,
    ST_FINAL  = 3'd4
  } fsm_e;

  // pLayer: bit i moves to 16*i mod 63, bit 63 stays where it is.
  function automatic logic [STATE_W-1:0] p_layer(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] r;
    r = '0;
    for (int i = 0; i < STATE_W - 1; i++) begin
      r[(16 * i) % (STATE_W - 1)] = s[i];
    end
    r[STATE_W-1] = s[STATE_W-1];
    return r;
  endfunction

  // Key register rotated left by 61 positions.
  function automatic logic [KEY_W-1:0] key_rotate(input logic [KEY_W-1:0] k);
    return {k[18:0], k[79:19]};
  endfunction

  // One key-schedule step. The substituted top nibble comes from an external
  // s_box fed with the top nibble of key_rotate(k).
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0]   k,
                                                  input logic [ROUND_W-1:0] round,
                                                  input logic [NIB_W-1:0]   sbox_nib);
    logic [KEY_W-1:0] r;
    r          = key_rotate(k);
    r[79:76]   = sbox_nib;
    r[19:15]   = r[19:15] ^ round;
    return r;
  endfunction

endpackage

// File: rtl/s_box.sv
// PRESENT 4-bit substitution box, purely combinational.
module s_box (
  input  logic [3:0] nib,
  output logic [3:0] sub
);

  // Table lookup of the PRESENT S-box.
  always_comb begin
    case (nib)
      4'h0:    sub = 4'hC;
      4'h1:    sub = 4'h5;
      4'h2:    sub = 4'h6;
      4'h3:    sub = 4'hB;
      4'h4:    sub = 4'h9;
      4'h5:    sub = 4'h0;
      4'h6:    sub = 4'hA;
      4'h7:    sub = 4'hD;
      4'h8:    sub = 4'h3;
      4'h9:    sub = 4'hE;
      4'hA:    sub = 4'hF;
      4'hB:    sub = 4'h8;
      4'hC:    sub = 4'h4;
      4'hD:    sub = 4'h7;
      4'hE:    sub = 4'h1;
      default: sub = 4'h2;
    endcase
  end

endmodule

// File: rtl/present_serial_core.sv
// Nibble-serial PRESENT-80 encryption core. Each round is one addRoundKey
// cycle, sixteen sLayer cycles (one nibble through a shared s_box while the
// state rotates right) and one pLayer/key-update cycle; final whitening
// follows the last round.
module present_serial_core
  import present_pkg::*;
#(
  parameter int unsigned ROUNDS = 31
) (
  input  logic               Clk_ik,
  input  logic               Rst_ir,
  input  logic               Start_i,
  input  logic [STATE_W-1:0] Plaintext_ib,
  input  logic [KEY_W-1:0]   Key_ib,
  output logic               Busy_o,
  output logic               Done_o,
  output logic [STATE_W-1:0] Ciphertext_ob
);

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(ROUNDS);

  fsm_e               fsm;
  fsm_e               fsm_next;
  logic [STATE_W-1:0] blk;
  logic [KEY_W-1:0]   key;
  logic [KEY_W-1:0]   key_rot;
  logic [ROUND_W-1:0] round;
  logic [NIB_W-1:0]   nib;
  logic [NIB_W-1:0]   data_sub;
  logic [NIB_W-1:0]   key_sub;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] ciphertext;

  assign key_rot = key_rotate(key);

  s_box u_data_sbox (
    .nib (blk[3:0]),
    .sub (data_sub)
  );

  s_box u_key_sbox (
    .nib (key_rot[79:76]),
    .sub (key_sub)
  );

  // FSM state register.
  // NOTE: registers are written with non-blocking <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) fsm <= ST_IDLE;
    else        fsm <= fsm_next;
  end

  // Next-state sequencing through the round phases.
  // NOTE: fsm_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fsm_next = fsm;
    case (fsm)
      ST_IDLE:   if (Start_i) fsm_next = ST_ADDKEY;
      ST_ADDKEY: fsm_next = ST_SBOX;
      ST_SBOX:   if (nib == 4'd15) fsm_next = ST_PERM;
      ST_PERM:   fsm_next = (round == LAST_ROUND) ? ST_FINAL : ST_ADDKEY;
      ST_FINAL:  fsm_next = ST_IDLE;
      default:   fsm_next = ST_IDLE;
    endcase
  end

  // Datapath: state, key schedule and counters, stepped by the FSM phase.
  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      blk   <= '0;
      key   <= '0;
      round <= '0;
      nib   <= '0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (Start_i) begin
            blk   <= Plaintext_ib;
            key   <= Key_ib;
            round <= ROUND_W'(1);
          end
        end
        ST_ADDKEY: begin
          blk <= blk ^ key[79:16];
          nib <= '0;
        end
        ST_SBOX: begin
          // Rotate right one nibble, substituting the nibble that wraps to the top.
          blk <= {data_sub, blk[63:4]};
          nib <= nib + 4'd1;
        end
        ST_PERM: begin
          blk <= p_layer(blk);
          key <= key_update(key, round, key_sub);
          if (round != LAST_ROUND) round <= round + ROUND_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result register and status flags. Busy spans the Done cycle as well.
  always_ff @(posedge Clk_ik or posedge Rst_ir) begin
    if (Rst_ir) begin
      ciphertext <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= (fsm == ST_FINAL);
      busy <= (fsm_next != ST_IDLE) || (fsm == ST_FINAL);
      if (fsm == ST_FINAL) ciphertext <= blk ^ key[79:16];
    end
  end

  assign Busy_o        = busy;
  assign Done_o        = done;
  assign Ciphertext_ob = ciphertext;

endmodule

// File: tb/tb_present_serial_core.sv
// Scoreboard bench for present_serial_core: stimulus pushes expected results,
// a monitor pops and compares on every Done_o and tracks Busy_o each cycle.
module tb_present_serial_core;

  localparam int LATENCY = 560;
  localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [63:0] ONES64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [79:0] ONES80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic [63:0] ct;
    int          acc;
  } job_t;

  logic        Clk_ik = 1'b0;
  logic        Rst_ir = 1'b1;
  logic        Start_i = 1'b0;
  logic [63:0] Plaintext_ib = '0;
  logic [79:0] Key_ib = '0;
  logic        Busy_o;
  logic        Done_o;
  logic [63:0] Ciphertext_ob;

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  job_t sb[$];
  job_t mon_job;
  logic mon_busy;

  present_serial_core dut (
    .Clk_ik        (Clk_ik),
    .Rst_ir        (Rst_ir),
    .Start_i       (Start_i),
    .Plaintext_ib  (Plaintext_ib),
    .Key_ib        (Key_ib),
    .Busy_o        (Busy_o),
    .Done_o        (Done_o),
    .Ciphertext_ob (Ciphertext_ob)
  );

  always #5 Clk_ik = ~Clk_ik;
  always @(posedge Clk_ik) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Textbook PRESENT-80: whole-state layers, 31 rounds, final whitening.
  function automatic logic [63:0] present_ref(input logic [63:0] pt, input logic [79:0] k);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] kk;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = SBOX[s[4*n +: 4]];
      t = '0;
      for (int i = 0; i < 64; i++) t[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s  = t;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = SBOX[kk[79:76]];
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  function automatic logic [79:0] rand_key();
    return {16'($urandom), $urandom, $urandom};
  endfunction

  // Monitor: Busy_o every cycle, ciphertext and latency on each Done_o.
  always @(negedge Clk_ik) begin
    if (mon_en && !Rst_ir) begin
      mon_busy = (sb.size() > 0) && (cyc > sb[0].acc);
      check("busy", 64'(Busy_o), 64'(mon_busy));
      if (Done_o) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got Done_o=1, expected no pending job (cycle %0d)", cyc);
        end else begin
          mon_job = sb.pop_front();
          check("ciphertext", Ciphertext_ob, mon_job.ct);
          check("latency", 64'(cyc - mon_job.acc), 64'(LATENCY));
        end
      end
    end
  end

  // Drive one accepted start (sampled at the end of the current cycle).
  task automatic issue(input logic [63:0] pt, input logic [79:0] k, input logic [63:0] exp);
    job_t j;
    @(negedge Clk_ik);
    Start_i      = 1'b1;
    Plaintext_ib = pt;
    Key_ib       = k;
    j.ct  = exp;
    j.acc = cyc;
    sb.push_back(j);
    @(negedge Clk_ik);
    Start_i      = 1'b0;
    Plaintext_ib = {$urandom, $urandom};
    Key_ib       = rand_key();
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < LATENCY + 40 && !seen; i++) begin
      @(negedge Clk_ik);
      if (Done_o) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no Done_o, expected one within %0d cycles", LATENCY + 40);
    end
  endtask

  task automatic spurious_start();
    Start_i      = 1'b1;
    Plaintext_ib = {$urandom, $urandom};
    Key_ib       = rand_key();
    @(negedge Clk_ik);
    Start_i      = 1'b0;
  endtask

  initial begin
    logic [63:0] pt;
    logic [79:0] k;

    #1;
    check("reset_busy", 64'(Busy_o), 64'd0);
    check("reset_done", 64'(Done_o), 64'd0);
    check("reset_ct", Ciphertext_ob, 64'd0);
    repeat (3) @(negedge Clk_ik);
    Rst_ir = 1'b0;
    mon_en = 1'b1;

    // Published vectors.
    issue(64'd0, 80'd0, 64'h5579C1387B228445);
    wait_done();
    issue(64'd0, ONES80, 64'hE72C46C0F5945049);
    wait_done();
    issue(ONES64, 80'd0, 64'hA112FFC72F68417B);
    wait_done();

    // Back-to-back: restart on the cycle after Done_o.
    issue(ONES64, ONES80, 64'h3333DCD3213210D2);
    wait_done();
    issue(ONES64, ONES80, 64'h3333DCD3213210D2);
    wait_done();
    check("ct_held", Ciphertext_ob, 64'h3333DCD3213210D2);

    // Starts while busy are ignored.
    issue(64'd0, 80'd0, 64'h5579C1387B228445);
    repeat (3) @(negedge Clk_ik);
    spurious_start();
    repeat (293) @(negedge Clk_ik);
    spurious_start();
    wait_done();

    // Reset mid-operation aborts without a Done_o.
    pt = {$urandom, $urandom};
    k  = rand_key();
    issue(pt, k, present_ref(pt, k));
    repeat (198) @(negedge Clk_ik);
    Rst_ir = 1'b1;
    sb.delete();
    repeat (2) @(negedge Clk_ik);
    check("abort_busy", 64'(Busy_o), 64'd0);
    check("abort_done", 64'(Done_o), 64'd0);
    check("abort_ct", Ciphertext_ob, 64'd0);
    Rst_ir = 1'b0;
    issue(64'd0, ONES80, 64'hE72C46C0F5945049);
    wait_done();

    // Random traffic against the reference model.
    for (int n = 0; n < 6; n++) begin
      pt = {$urandom, $urandom};
      k  = rand_key();
      issue(pt, k, present_ref(pt, k));
      wait_done();
      repeat ($urandom_range(0, 3)) @(negedge Clk_ik);
    end

    repeat (5) @(negedge Clk_ik);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #(10 * 30000);
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
